vec_aggregator: RTL
===================

VEC_AGGREGATOR -- requirements
Module: vec_aggregator

Interface
REQ-001 Parameter DEPTH, default 16, number of DATA_WIDTH elements per input vector; SHALL equal VECTOR_LENGTH/DATA_WIDTH.
REQ-002 Parameter MAX_NEIGH, default 16, maximum vectors aggregated per job.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port arst_n  input  1  reset; asynchronous, active-low.
REQ-005 Port start  input  1  single-cycle job start; honoured only in IDLE.
REQ-006 Port n_neigh  input  $clog2(MAX_NEIGH)+1  vectors to aggregate; sampled on an honoured start.
REQ-007 Port vec_in  input  VECTOR_LENGTH  packed signed vector from the upstream collector; element 0 in the MSBs.
REQ-008 Port vec_valid  input  1  vec_in holds a complete vector (driven by the collector's full).
REQ-009 Port vec_ready  output  1  block accepts vec_in this cycle (drives the collector's re).
REQ-010 Port sum_out  output  DEPTH*ACC_WIDTH  packed signed element-wise sums; element 0 in the MSBs.
REQ-011 Port out_valid  output  1  sum_out is final.
REQ-012 Port out_ready  input  1  consumer takes sum_out.
REQ-013 Port busy  output  1  high in every state except IDLE.

Function
REQ-014 FSM states SHALL be IDLE, ACCUM and DONE.
REQ-015 IDLE + start SHALL clear all accumulators and the vector counter, latch n_neigh (clamped to MAX_NEIGH), and go to ACCUM; go to DONE instead if the latched value is 0.
REQ-016 vec_ready SHALL be high only in ACCUM, driven combinationally from state.
REQ-017 A vector is accepted on a rising edge with vec_valid && vec_ready; each element i SHALL be sign-extended to ACC_WIDTH and added to accumulator i.
REQ-018 Each acceptance SHALL increment the vector counter; the acceptance that brings the counter to the latched n_neigh SHALL move the FSM to DONE.
REQ-019 Latency: last vector accepted at edge t -> out_valid high after edge t, with sum_out including that vector.
REQ-020 In DONE, out_valid SHALL be high and sum_out stable until out_valid && out_ready, then return to IDLE.
REQ-021 start SHALL be ignored in ACCUM and DONE, including in the cycle in which DONE exits.
REQ-022 vec_valid without vec_ready SHALL not change any state.
REQ-023 ACC_WIDTH = DATA_WIDTH + $clog2(MAX_NEIGH)+1; sums SHALL never overflow, so no wrap or saturation logic is required.
REQ-024 sum_out SHALL hold the last result in IDLE until the next honoured start clears it.

Reset
REQ-025 arst_n low SHALL immediately force IDLE, with counter 0, accumulators 0, sum_out 0, out_valid 0, vec_ready 0 and busy 0.
REQ-026 Reset mid-job SHALL abandon the job; no partial result is presented after reset release.
REQ-027 The first honoured start after reset SHALL behave identically to any later start.

Structure
REQ-028 ACC_WIDTH and the FSM state enum SHALL live in my_pkg next to DATA_WIDTH and VECTOR_LENGTH.
REQ-029 Counter, latched n_neigh and state SHALL use the team's register sub-module (clk, arst_n, din, qout, we).
REQ-030 The accumulator array SHALL be a single always_ff block with asynchronous reset; no other sub-module is permitted.

Verification
REQ-031 Single vector: start with n_neigh=1, one vector with all elements 3 -> vec_ready drops after acceptance, out_valid rises the next cycle, every sum element = 3.
REQ-032 Signed mix: n_neigh=3, vectors with element0 = -128, 127, -1 -> sum element0 = -2 with no overflow.
REQ-033 Full depth: n_neigh=MAX_NEIGH, all elements DATA_WIDTH max negative -> each sum = MAX_NEIGH * min value, exactly representable.
REQ-034 Zero job: start with n_neigh=0 -> DONE next cycle, sum_out all zero, vec_ready never high.
REQ-035 Backpressure: out_ready held low 5 cycles while vec_valid=1 and start pulses -> sum_out stable, no vector accepted, start ignored; then out_ready=1 -> IDLE.
REQ-036 Mid-job reset: arst_n low after 2 of 4 vectors -> all outputs 0 immediately; a new 1-vector job then yields only that vector's values.

Source files
------------

// File: rtl/my_pkg.sv
// Shared widths and FSM encoding for the vector aggregator.
package my_pkg;

  localparam int DATA_WIDTH        = 8;
  localparam int VECTOR_LENGTH     = 128;
  localparam int MAX_NEIGH_DEFAULT = 16;

  // Wide enough that MAX_NEIGH_DEFAULT extreme-valued elements can never overflow.
  localparam int ACC_WIDTH = DATA_WIDTH + $clog2(MAX_NEIGH_DEFAULT) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/vec_aggregator_reg.sv
// Generic write-enabled register with asynchronous active-low clear.
module vec_aggregator_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             we,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] qout
);

  // NOTE: state is updated with <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)  qout <= '0;
    else if (we)  qout <= din;
  end

endmodule

// File: rtl/vec_aggregator.sv
// Accumulates n_neigh signed vectors element-wise and presents the sums
// with a valid/ready handshake.
module vec_aggregator
  import my_pkg::*;
#(
  parameter int DEPTH     = VECTOR_LENGTH / DATA_WIDTH,
  parameter int MAX_NEIGH = MAX_NEIGH_DEFAULT
) (
  input  logic                           clk,
  input  logic                           arst_n,
  input  logic                           start,
  input  logic [$clog2(MAX_NEIGH):0]     n_neigh,
  input  logic [VECTOR_LENGTH-1:0]       vec_in,
  input  logic                           vec_valid,
  output logic                           vec_ready,
  output logic [DEPTH*ACC_WIDTH-1:0]     sum_out,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           busy
);

  localparam int CW  = $clog2(MAX_NEIGH) + 1;
  localparam int EXT = ACC_WIDTH - DATA_WIDTH;

  logic [1:0]    state_q;
  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, n_lat, n_clamp;
  logic          cnt_we, n_we;
  logic          clear, accept;

  logic signed [ACC_WIDTH-1:0] acc [DEPTH];
  logic signed [ACC_WIDTH-1:0] ext [DEPTH];

  vec_aggregator_reg #(.WIDTH(2)) u_state (
    .clk(clk), .arst_n(arst_n), .we(1'b1), .din(state_nxt), .qout(state_q)
  );

  vec_aggregator_reg #(.WIDTH(CW)) u_cnt (
    .clk(clk), .arst_n(arst_n), .we(cnt_we), .din(cnt_nxt), .qout(cnt)
  );

  vec_aggregator_reg #(.WIDTH(CW)) u_n_lat (
    .clk(clk), .arst_n(arst_n), .we(n_we), .din(n_clamp), .qout(n_lat)
  );

  assign state   = state_t'(state_q);
  assign n_clamp = (n_neigh > CW'(MAX_NEIGH)) ? CW'(MAX_NEIGH) : n_neigh;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    cnt_we    = 1'b0;
    n_we      = 1'b0;
    clear     = 1'b0;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          clear     = 1'b1;
          n_we      = 1'b1;
          cnt_we    = 1'b1;
          cnt_nxt   = '0;
          state_nxt = (n_clamp == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (vec_valid) begin
          accept  = 1'b1;
          cnt_we  = 1'b1;
          cnt_nxt = cnt + CW'(1);
          if (cnt_nxt == n_lat) state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign vec_ready = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // Element 0 sits in the MSBs of vec_in.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ext[i] = {{EXT{vec_in[VECTOR_LENGTH-1-i*DATA_WIDTH]}},
                vec_in[VECTOR_LENGTH-1-i*DATA_WIDTH -: DATA_WIDTH]};
    end
  end

  // NOTE: the accumulator array is reset because sum_out must read 0 out of reset.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < DEPTH; i++) acc[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) acc[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < DEPTH; i++) acc[i] <= acc[i] + ext[i];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_pack
    assign sum_out[(DEPTH-g)*ACC_WIDTH-1 -: ACC_WIDTH] = acc[g];
  end

endmodule
